// File: rtl/ppe_w512_rr_ctrl_pkg.sv
// ppe_pkg: shared constants and FSM state type for the round-robin request controller
//   W       request vector width (encoder width)
//   IDX_W   source index width
//   PPE_LAT encoder latency from Req/P_enc to o_value valid
package ppe_pkg;
   localparam int W       = 512;
   localparam int IDX_W   = 9;
   localparam int PPE_LAT = 3;
   typedef enum logic [1:0] {st_idle, st_search, st_wait, st_grant} state_t;
endpackage

// File: rtl/ppe_w512_rr_ctrl_if.sv
// ppe_w512_rr_ctrl_if: request, encoder and grant signals of the round-robin controller
//   set_valid/set_idx               request marking
//   ppe_req/ppe_ptr                 snapshot and pointer to the encoder
//   ppe_value/ppe_value_inc/valid   encoder result
//   gnt_valid/gnt_idx/gnt_ready     grant handshake
//   pending_cnt/busy                status
//   slave: controller side, master: environment side
interface ppe_w512_rr_ctrl_if;
   import ppe_pkg::*;
   logic             set_valid;
   logic [IDX_W-1:0] set_idx;
   logic [W-1:0]     ppe_req;
   logic [IDX_W-1:0] ppe_ptr;
   logic [IDX_W-1:0] ppe_value;
   logic [IDX_W-1:0] ppe_value_inc;
   logic             ppe_valid;
   logic             gnt_valid;
   logic [IDX_W-1:0] gnt_idx;
   logic             gnt_ready;
   logic [IDX_W:0]   pending_cnt;
   logic             busy;
   modport slave (
      input  set_valid, set_idx, ppe_value, ppe_value_inc, ppe_valid, gnt_ready,
      output ppe_req, ppe_ptr, gnt_valid, gnt_idx, pending_cnt, busy
   );
   modport master (
      output set_valid, set_idx, ppe_value, ppe_value_inc, ppe_valid, gnt_ready,
      input  ppe_req, ppe_ptr, gnt_valid, gnt_idx, pending_cnt, busy
   );
endinterface

// File: rtl/ppe_w512_rr_ctrl.sv
// ppe_w512_rr_ctrl: round-robin request controller feeding a pipelined programmable priority encoder
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  controller side of ppe_w512_rr_ctrl_if (requests in, encoder snapshot/pointer out,
//        encoder result in, valid/ready grant out, pending count and busy status out)
module ppe_w512_rr_ctrl
   import ppe_pkg::*;
(
   input logic               clk,
   input logic               rst,
   ppe_w512_rr_ctrl_if.slave bus
);
   localparam logic [1:0] WAIT_INIT = 2'(PPE_LAT - 1);
   state_t           state, state_nxt;
   logic [W-1:0]     pending, pending_nxt, req_q;
   logic [IDX_W:0]   cnt;
   logic [IDX_W-1:0] ptr_q, nxt_ptr, gnt_idx_q;
   logic [1:0]       wait_cnt;
   logic             hs, set_new, clr_eff;
   // A set to the index being retired in the same cycle wins, so the clear is cancelled.
   always_comb begin
      hs          = (state == st_grant) && bus.gnt_ready;
      set_new     = bus.set_valid && !pending[bus.set_idx];
      clr_eff     = hs && !(bus.set_valid && bus.set_idx == gnt_idx_q);
      pending_nxt = pending;
      if (hs) pending_nxt[gnt_idx_q] = 1'b0;
      if (bus.set_valid) pending_nxt[bus.set_idx] = 1'b1;
   end
   always_comb begin
      state_nxt = state;
      case (state)
         st_idle:   state_nxt = |pending ? st_search : st_idle;
         st_search: state_nxt = st_wait;
         st_wait:   if (wait_cnt == 2'd0) state_nxt = bus.ppe_valid ? st_grant : st_idle;
         st_grant:  if (hs) state_nxt = |pending_nxt ? st_search : st_idle;
         default:   state_nxt = st_idle;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= st_idle;
      else     state <= state_nxt;
   // Snapshot is frozen from SEARCH through the sample cycle; leaving GRANT uses the
   // post-retire bitmap so the just-granted source is not searched again.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         pending   <= '0;
         cnt       <= '0;
         req_q     <= '0;
         ptr_q     <= '0;
         nxt_ptr   <= '0;
         gnt_idx_q <= '0;
         wait_cnt  <= '0;
      end else begin
         pending <= pending_nxt;
         cnt     <= cnt + {{IDX_W{1'b0}}, set_new} - {{IDX_W{1'b0}}, clr_eff};
         if (state_nxt == st_search) req_q <= (state == st_grant) ? pending_nxt : pending;
         if (state == st_search) wait_cnt <= WAIT_INIT;
         else if (state == st_wait) wait_cnt <= wait_cnt - 2'd1;
         if (state == st_wait && wait_cnt == 2'd0 && bus.ppe_valid) begin
            gnt_idx_q <= bus.ppe_value;
            nxt_ptr   <= bus.ppe_value_inc;
         end
         if (hs) ptr_q <= nxt_ptr;
      end
   assign bus.ppe_req     = req_q;
   assign bus.ppe_ptr     = ptr_q;
   assign bus.gnt_valid   = (state == st_grant);
   assign bus.gnt_idx     = gnt_idx_q;
   assign bus.pending_cnt = cnt;
   assign bus.busy        = (state != st_idle);
endmodule

// File: tb/tb_ppe_w512_rr_ctrl.sv
// tb_ppe_w512_rr_ctrl: directed self-checking bench with a 3-cycle behavioural encoder
module tb_ppe_w512_rr_ctrl;
   import ppe_pkg::*;
   logic clk, rst;
   int   checks, errors;
   ppe_w512_rr_ctrl_if bus();
   ppe_w512_rr_ctrl u_dut (.clk(clk), .rst(rst), .bus(bus));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   function automatic logic [8:0] enc(input logic [511:0] r, input logic [8:0] p);
      logic [8:0] j;
      enc = p;
      for (int k = 511; k >= 0; k--) begin
         j = p + 9'(k);
         if (r[j]) enc = j;
      end
   endfunction
   logic [2:0] ev;
   logic [8:0] ex0, ex1, ex2;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         ev <= '0; ex0 <= '0; ex1 <= '0; ex2 <= '0;
      end else begin
         ev  <= {ev[1:0], |bus.ppe_req};
         ex0 <= enc(bus.ppe_req, bus.ppe_ptr);
         ex1 <= ex0;
         ex2 <= ex1;
      end
   assign bus.ppe_valid     = ev[2];
   assign bus.ppe_value     = ex2;
   assign bus.ppe_value_inc = ex2 + 9'd1;
   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic pulse_set(input int idx);
      bus.set_valid = 1'b1;
      bus.set_idx   = 9'(idx);
      step();
      bus.set_valid = 1'b0;
   endtask
   task automatic wait_gnt(input int start, output int n);
      n = start;
      do begin
         step();
         n++;
      end while (!bus.gnt_valid && n < 64);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1);
   end
   initial begin
      int n;
      logic stable, seen;
      logic [W-1:0] e;
      checks = 0; errors = 0;
      bus.set_valid = 1'b0; bus.set_idx = '0; bus.gnt_ready = 1'b0;
      rst = 1'b1;
      step(); step();
      chk("rst_req", bus.ppe_req, '0);
      chk("rst_ptr", bus.ppe_ptr, 0);
      chk("rst_gv", bus.gnt_valid, 0);
      chk("rst_gi", bus.gnt_idx, 0);
      chk("rst_cnt", bus.pending_cnt, 0);
      chk("rst_busy", bus.busy, 0);
      rst = 1'b0;
      step();
      // single request
      pulse_set(5);
      wait_gnt(1, n);
      chk("t1_lat", n, 6);
      chk("t1_idx", bus.gnt_idx, 5);
      e = '0; e[5] = 1'b1;
      chk("t1_snap", bus.ppe_req, e);
      bus.gnt_ready = 1'b1; step(); bus.gnt_ready = 1'b0;
      chk("t1_ptr", bus.ppe_ptr, 6);
      chk("t1_cnt", bus.pending_cnt, 0);
      chk("t1_gv", bus.gnt_valid, 0);
      chk("t1_busy", bus.busy, 0);
      // three requests, pointer restarted at 0
      rst = 1'b1; #2; rst = 1'b0;
      step();
      chk("t2_ptr0", bus.ppe_ptr, 0);
      pulse_set(3); pulse_set(100); pulse_set(400);
      bus.gnt_ready = 1'b1;
      wait_gnt(3, n);
      chk("t2_lat", n, 6);
      chk("t2_idx0", bus.gnt_idx, 3);
      chk("t2_cnt0", bus.pending_cnt, 3);
      wait_gnt(0, n);
      chk("t2_gap1", n, 5);
      chk("t2_idx1", bus.gnt_idx, 100);
      chk("t2_cnt1", bus.pending_cnt, 2);
      wait_gnt(0, n);
      chk("t2_gap2", n, 5);
      chk("t2_idx2", bus.gnt_idx, 400);
      chk("t2_cnt2", bus.pending_cnt, 1);
      step();
      bus.gnt_ready = 1'b0;
      chk("t2_cnt3", bus.pending_cnt, 0);
      chk("t2_ptr", bus.ppe_ptr, 401);
      chk("t2_busy", bus.busy, 0);
      // pointer wrap: grant 299 then {2, 511} from pointer 300
      pulse_set(299);
      wait_gnt(1, n);
      chk("t3_idx299", bus.gnt_idx, 299);
      pulse_set(2); pulse_set(511);
      chk("t3_hold", bus.gnt_idx, 299);
      chk("t3_cnt", bus.pending_cnt, 3);
      bus.gnt_ready = 1'b1;
      step();
      chk("t3_ptr300", bus.ppe_ptr, 300);
      e = '0; e[2] = 1'b1; e[511] = 1'b1;
      chk("t3_snap", bus.ppe_req, e);
      wait_gnt(1, n);
      chk("t3_gap511", n, 5);
      chk("t3_idx511", bus.gnt_idx, 511);
      wait_gnt(0, n);
      chk("t3_idx2", bus.gnt_idx, 2);
      chk("t3_ptr0", bus.ppe_ptr, 0);
      step();
      bus.gnt_ready = 1'b0;
      chk("t3_ptr3", bus.ppe_ptr, 3);
      // same-cycle set and retire of 7
      pulse_set(7);
      wait_gnt(1, n);
      chk("t4_idx", bus.gnt_idx, 7);
      chk("t4_cnt", bus.pending_cnt, 1);
      bus.set_valid = 1'b1; bus.set_idx = 9'd7; bus.gnt_ready = 1'b1;
      step();
      bus.set_valid = 1'b0; bus.gnt_ready = 1'b0;
      chk("t4_cnt_kept", bus.pending_cnt, 1);
      chk("t4_busy", bus.busy, 1);
      chk("t4_ptr", bus.ppe_ptr, 8);
      wait_gnt(1, n);
      chk("t4_gap", n, 5);
      chk("t4_idx_again", bus.gnt_idx, 7);
      bus.gnt_ready = 1'b1; step(); bus.gnt_ready = 1'b0;
      chk("t4_cnt0", bus.pending_cnt, 0);
      // backpressure for 20 cycles with sets arriving
      pulse_set(10);
      wait_gnt(1, n);
      chk("t5_idx", bus.gnt_idx, 10);
      stable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         bus.set_valid = (i == 3 || i == 7);
         bus.set_idx   = (i == 3) ? 9'd20 : 9'd9;
         step();
         stable &= bus.gnt_valid && bus.gnt_idx == 9'd10;
      end
      bus.set_valid = 1'b0;
      chk("t5_stable", stable, 1);
      chk("t5_cnt", bus.pending_cnt, 3);
      bus.gnt_ready = 1'b1;
      step();
      chk("t5_ptr", bus.ppe_ptr, 11);
      e = '0; e[9] = 1'b1; e[20] = 1'b1;
      chk("t5_snap", bus.ppe_req, e);
      chk("t5_cnt2", bus.pending_cnt, 2);
      wait_gnt(1, n);
      chk("t5_idx20", bus.gnt_idx, 20);
      wait_gnt(0, n);
      chk("t5_gap", n, 5);
      chk("t5_idx9", bus.gnt_idx, 9);
      step();
      bus.gnt_ready = 1'b0;
      chk("t5_cnt0", bus.pending_cnt, 0);
      chk("t5_ptr10", bus.ppe_ptr, 10);
      // reset while waiting for the encoder
      pulse_set(50);
      step(); step();
      chk("t6_busy", bus.busy, 1);
      rst = 1'b1;
      #1;
      chk("t6_req", bus.ppe_req, '0);
      chk("t6_ptr", bus.ppe_ptr, 0);
      chk("t6_gv", bus.gnt_valid, 0);
      chk("t6_gi", bus.gnt_idx, 0);
      chk("t6_cnt", bus.pending_cnt, 0);
      chk("t6_busyr", bus.busy, 0);
      #1;
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step();
         seen |= bus.gnt_valid | bus.busy;
      end
      chk("t6_quiet", seen, 0);
      pulse_set(60);
      wait_gnt(1, n);
      chk("t6_lat", n, 6);
      chk("t6_idx", bus.gnt_idx, 60);
      bus.gnt_ready = 1'b1; step(); bus.gnt_ready = 1'b0;
      chk("t6_ptr61", bus.ppe_ptr, 61);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
